// File: rtl/clkdiv_sched.sv
// Ratio scheduler for the /2-/4 clock divider: arbitrates two requesters and switches div4not2 only at the divider's pre-zero phase.
// Optional CLKDIV_SCHED_LOCK_EN adds a lock input that freezes new grants while high.
module clkdiv_sched #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic        RESET_DIV4    = 1'b1
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic [1:0] div_phase,
  input  logic       req_a,
  input  logic       sel_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic       sel_b,
  output logic       ack_b,
  output logic       div4not2,
  output logic       busy
`ifdef CLKDIV_SCHED_LOCK_EN
  ,
  input  logic       lock
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PHASE = 2'd1,
    SETTLE     = 2'd2,
    ACK        = 2'd3
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t     state, state_n;
  logic       owner, owner_n;
  logic       target, target_n;
  logic       last_grant, last_grant_n;
  logic [3:0] cnt, cnt_n;
  logic       div_n;
  logic       grant_en;
  logic       pick;

  // Phase the divider occupies in the cycle just before it returns to 00.
  function automatic logic [1:0] pre_zero(input logic div4);
    return div4 ? 2'b01 : 2'b11;
  endfunction

`ifdef CLKDIV_SCHED_LOCK_EN
  assign grant_en = !lock;
`else
  assign grant_en = 1'b1;
`endif

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    target_n     = target;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    div_n        = div4not2;
    pick         = OWN_A;
    case (state)
      IDLE: begin
        if (grant_en && (req_a || req_b)) begin
          if (req_a && req_b) pick = (last_grant == OWN_A) ? OWN_B : OWN_A;
          else                pick = req_b ? OWN_B : OWN_A;
          owner_n  = pick;
          target_n = (pick == OWN_B) ? sel_b : sel_a;
          state_n  = (target_n == div4not2) ? ACK : WAIT_PHASE;
        end
      end
      WAIT_PHASE: begin
        if (div_phase == pre_zero(div4not2)) begin
          div_n   = target;
          cnt_n   = 4'(SETTLE_CYCLES);
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = ACK;
      end
      ACK: begin
        last_grant_n = owner;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Acks are registered so they are high exactly while the FSM sits in ACK.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_A;
      target     <= RESET_DIV4;
      last_grant <= OWN_B;
      cnt        <= 4'd0;
      div4not2   <= RESET_DIV4;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      target     <= target_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      div4not2   <= div_n;
      ack_a      <= (state_n == ACK) && (owner_n == OWN_A);
      ack_b      <= (state_n == ACK) && (owner_n == OWN_B);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: a divider model drives div_phase; expected {owner, ratio} per ack is queued at request time.
module tb_clkdiv_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] div_phase;
  logic       req_a = 1'b0, sel_a = 1'b0, req_b = 1'b0, sel_b = 1'b0;
  logic       ack_a, ack_b, div4not2, busy;
`ifdef CLKDIV_SCHED_LOCK_EN
  logic       lock = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [1:0] sb[$];  // {owner (1 = B), div4not2 expected at ack}
  logic cur_div;

  logic       prev_rst = 1'b1;
  logic       prev_div = 1'b1;
  logic [1:0] prev_phase = 2'b00;

  always #5 clk = ~clk;

  clkdiv_sched #(.SETTLE_CYCLES(4), .RESET_DIV4(1'b1)) dut (
    .clkin(clk), .rst(rst), .div_phase(div_phase),
    .req_a(req_a), .sel_a(sel_a), .ack_a(ack_a),
    .req_b(req_b), .sel_b(sel_b), .ack_b(ack_b),
    .div4not2(div4not2), .busy(busy)
`ifdef CLKDIV_SCHED_LOCK_EN
    , .lock(lock)
`endif
  );

  // Divider: /2 = 00,11 ; /4 = 00,10,11,01 ; ratio is consulted only where the paths diverge.
  always @(posedge clk) begin
    if (rst) div_phase <= 2'b00;
    else begin
      case (div_phase)
        2'b00:   div_phase <= div4not2 ? 2'b10 : 2'b11;
        2'b10:   div_phase <= 2'b11;
        2'b11:   div_phase <= div4not2 ? 2'b01 : 2'b00;
        default: div_phase <= 2'b00;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard and glitch-free monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        check_val("ack_excl", 32'(ack_a & ack_b), 32'd0);
        if (sb.size() == 0) check_val("ack_unexp", 32'd1, 32'd0);
        else begin
          check_val("ack_owner", 32'(ack_b), 32'(sb[0][1]));
          check_val("ack_div", 32'(div4not2), 32'(sb[0][0]));
          void'(sb.pop_front());
        end
      end
      if (!prev_rst && div4not2 !== prev_div) begin
        check_val("tog_phase", 32'(prev_phase), prev_div ? 32'd1 : 32'd3);
        check_val("tog_zero", 32'(div_phase), 32'd0);
      end
    end
    prev_rst   <= rst;
    prev_div   <= div4not2;
    prev_phase <= div_phase;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits for the owner's ack, noting when the ratio first moved; then the requester drops req.
  task automatic wait_ack(input bit who, output int lat, output int fall);
    logic d0;
    bit   got;
    d0   = div4not2;
    lat  = 0;
    fall = 0;
    got  = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      tick();
      if (fall == 0 && div4not2 !== d0) fall = i;
      if ((who ? ack_b : ack_a) === 1'b1) begin
        lat = i;
        got = 1'b1;
      end
    end
    if (!got) check_val(who ? "ack_b_timeout" : "ack_a_timeout", 32'd0, 32'd1);
    if (who) req_b = 1'b0;
    else     req_a = 1'b0;
  endtask

  task automatic round(input logic sa, input logic sb_sel);
    int lat, fall;
    req_a = 1'b1; sel_a = sa;
    req_b = 1'b1; sel_b = sb_sel;
    sb.push_back({1'b0, sa});
    sb.push_back({1'b1, sb_sel});
    wait_ack(1'b0, lat, fall);
    wait_ack(1'b1, lat, fall);
    cur_div = sb_sel;
  endtask

  initial begin
    int lat, fall;
    bit seen_busy, seen_ack, hit;

    repeat (3) tick();
    check_val("rst_div", 32'(div4not2), 32'd1);
    check_val("rst_ack_a", 32'(ack_a), 32'd0);
    check_val("rst_ack_b", 32'(ack_b), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cur_div = 1'b1;
    repeat (2) tick();

    // /4 -> /2 switch by A: ratio moves within the /4 worst-case wait, ack 4 cycles after it moves.
    req_a = 1'b1; sel_a = 1'b0;
    sb.push_back({1'b0, 1'b0});
    wait_ack(1'b0, lat, fall);
    check_val("sw42_settle", 32'(lat - fall), 32'd4);
    check_val("sw42_wait", 32'(fall >= 2 && fall <= 5), 32'd1);
    tick();
    check_val("idle_busy", 32'(busy), 32'd0);
    cur_div = 1'b0;

    // Request matching the current ratio: req visible in cycle 0, ack in cycle 1, ratio untouched.
    repeat (2) tick();
    req_a = 1'b1; sel_a = 1'b0;
    sb.push_back({1'b0, 1'b0});
    wait_ack(1'b0, lat, fall);
    check_val("nosw_lat", 32'(lat), 32'd1);
    check_val("nosw_div", 32'(fall), 32'd0);

    // /2 -> /4 switch by B: at most 2 cycles of phase wait.
    tick();
    req_b = 1'b1; sel_b = 1'b1;
    sb.push_back({1'b1, 1'b1});
    wait_ack(1'b1, lat, fall);
    check_val("sw24_settle", 32'(lat - fall), 32'd4);
    check_val("sw24_wait", 32'(fall >= 2 && fall <= 3), 32'd1);
    cur_div = 1'b1;

    // Simultaneous requests: last grant was B, so A, B alternate in order.
    tick();
    round(1'b1, 1'b0);
    tick();
    round(1'b0, 1'b1);
    tick();
    round(1'b1, 1'b1);

    // Reset in SETTLE: ack dropped, ratio back to /4, nothing acked afterwards.
    tick();
    req_a = 1'b1; sel_a = ~cur_div;
    sb.push_back({1'b0, ~cur_div});
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (div4not2 !== cur_div) hit = 1'b1;
    end
    check_val("settle_reached", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_div", 32'(div4not2), 32'd1);
    check_val("midrst_ack", 32'(ack_a | ack_b), 32'd0);
    rst = 1'b0;
    req_a = 1'b0;
    sb.delete();
    cur_div = 1'b1;
    repeat (10) tick();
    check_val("post_rst_idle", 32'(busy), 32'd0);

    // After reset A wins the tie again.
    round(1'b0, 1'b1);

`ifdef CLKDIV_SCHED_LOCK_EN
    tick();
    lock = 1'b1;
    req_b = 1'b1; sel_b = 1'b0;
    seen_busy = 1'b0;
    seen_ack  = 1'b0;
    repeat (20) begin
      tick();
      seen_busy |= busy;
      seen_ack  |= ack_b;
    end
    check_val("lock_busy", 32'(seen_busy), 32'd0);
    check_val("lock_ack", 32'(seen_ack), 32'd0);
    sb.push_back({1'b1, 1'b0});
    lock = 1'b0;
    wait_ack(1'b1, lat, fall);
    check_val("unlock_settle", 32'(lat - fall), 32'd4);
`else
    seen_busy = 1'b0;
    seen_ack  = 1'b0;
`endif

    repeat (3) tick();
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
